// File: rtl/mul_arb_pkg.sv
// ============================================================================
// Module      : mul_arb_pkg
// Description : Shared widths, clog2 helper and job record for mul_share_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_arb_pkg;

  localparam int C_OPW     = 32;
  localparam int C_PW      = 64;
  localparam int C_JOB_IDW = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [C_JOB_IDW-1:0] id;
    logic [C_OPW-1:0]     x;
    logic [C_OPW-1:0]     y;
  } mul_job_t;

endpackage

`default_nettype wire

// File: rtl/mul_32k.sv
// ============================================================================
// Module      : mul_32k
// Description : Combinational 32x32 unsigned multiplier, full 64-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_32k (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [63:0] P
);

  assign P = {32'd0, X} * {32'd0, Y};

endmodule

`default_nettype wire

// File: rtl/mul_arb_rr.sv
// ============================================================================
// Module      : mul_arb_rr
// Description : Combinational round-robin picker starting at rr_ptr_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_arb_rr #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_any_o
);

  logic [IDW-1:0] w_idx;

  // Scan from farthest to nearest so the candidate closest to the pointer wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    w_idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(rr_ptr_i) + k) % NREQ);
      if (req_valid_i[w_idx]) begin
        gnt_o        = '0;
        gnt_o[w_idx] = 1'b1;
        gnt_idx_o    = w_idx;
        gnt_any_o    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_share_arb.sv
// ============================================================================
// Module      : mul_share_arb
// Description : Round-robin sharing of one mul_32k among NREQ requesters.
//               Define MUL_ARB_OUTREG_EN to add a registered result stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*C_OPW-1:0] req_x,
  input  logic [NREQ*C_OPW-1:0] req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [C_PW-1:0]       rsp_p,
  output logic [IDW-1:0]        rsp_id
);

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            a_valid_q, a_valid_d;
  mul_job_t        a_job_q, a_job_d;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_gnt_any;
  logic            w_a_leave;
  logic            w_a_accept;
  logic            w_xfer;
  logic [C_PW-1:0] w_prod;
  logic            w_unused_id;

  assign w_unused_id = ^{a_job_q.id, w_gnt_any};

  mul_arb_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_o       (w_gnt),
    .gnt_idx_o   (w_gnt_idx),
    .gnt_any_o   (w_gnt_any)
  );

  mul_32k u_mul (
    .X (a_job_q.x),
    .Y (a_job_q.y),
    .P (w_prod)
  );

`ifdef MUL_ARB_OUTREG_EN
  logic            b_valid_q, b_valid_d;
  logic [C_PW-1:0] b_p_q, b_p_d;
  logic [IDW-1:0]  b_id_q, b_id_d;

  assign w_a_leave = !b_valid_q || rsp_ready;

  always_comb begin
    b_valid_d = b_valid_q;
    b_p_d     = b_p_q;
    b_id_d    = b_id_q;
    if (w_a_leave) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_p_d  = w_prod;
        b_id_d = a_job_q.id[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_p_q     <= '0;
      b_id_q    <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_p_q     <= b_p_d;
      b_id_q    <= b_id_d;
    end
  end

  assign rsp_valid = b_valid_q;
  assign rsp_p     = b_p_q;
  assign rsp_id    = b_id_q;
`else
  assign w_a_leave = rsp_ready;
  assign rsp_valid = a_valid_q;
  assign rsp_p     = w_prod;
  assign rsp_id    = a_job_q.id[IDW-1:0];
`endif

  // Grant is suppressed in reset so no job is acknowledged and then discarded.
  assign w_a_accept = !a_valid_q || w_a_leave;
  assign req_ready  = (rst || !w_a_accept) ? '0 : w_gnt;
  assign w_xfer     = |req_ready;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    a_valid_d = a_valid_q;
    a_job_d   = a_job_q;
    if (w_xfer) begin
      a_valid_d  = 1'b1;
      a_job_d.id = C_JOB_IDW'(w_gnt_idx);
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt_idx == IDW'(i)) begin
          a_job_d.x = req_x[i*C_OPW +: C_OPW];
          a_job_d.y = req_y[i*C_OPW +: C_OPW];
        end
      end
      rr_ptr_d = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end else if (w_a_leave) begin
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      a_valid_q <= 1'b0;
      a_job_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      a_valid_q <= a_valid_d;
      a_job_q   <= a_job_d;
    end
  end

endmodule

`default_nettype wire
